mdio_responder: RTL and testbench

//  Clause 22 MDIO management-slave (PHY side) emulation: counterpart of the management MDIO master driving

---
 rtl/mdio_responder.sv | 214 +++++++++++++++++++++
 tb/tb_mdio_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// Clause 22 MDIO management slave: oversamples MDC/MDIO in the fabric clock, decodes frames for PHY_ADDR
// and bridges reads/writes onto a 32 x 16-bit register port.
module mdio_responder #(
   parameter logic [4:0] PHY_ADDR     = 5'd0,
   parameter int         PREAMBLE_MIN = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mdc,
   input  logic        mdio_in,
   output logic        mdio_out,
   output logic        mdio_oe,
   output logic [4:0]  reg_addr,
   output logic        reg_rd_en,
   input  logic        reg_rd_valid,
   input  logic [15:0] reg_rd_data,
   output logic        reg_wr_en,
   output logic [15:0] reg_wr_data,
   output logic        frame_error
);

   localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

   typedef enum logic [3:0] {
      IDLE, ST2, OP, PHYAD, REGAD, SKIP,
      RD_TA1, RD_TA2, RD_DATA, WR_TA1, WR_TA2, WR_DATA
   } state_t;

   state_t      state;
   logic        mdc_meta, mdc_sync, mdc_prev;
   logic        mdio_meta, mdio_sync;
   logic [5:0]  pre_cnt;
   logic [4:0]  bit_cnt;
   logic        op_hi, op_rd;
   logic [4:0]  phyad, regad;
   logic [15:0] shreg;
   logic        rd_got;
   logic [15:0] rd_word;

   logic        mdc_rise;
   logic [15:0] rd_pick;
   logic        rd_none;

   always_comb begin
      mdc_rise = mdc_sync & ~mdc_prev;
      // A strobe arriving exactly on the TA2 edge cycle still counts.
      rd_none  = ~rd_got & ~reg_rd_valid;
      rd_pick  = rd_got ? rd_word : (reg_rd_valid ? reg_rd_data : 16'hFFFF);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mdc_meta    <= 1'b0;
         mdc_sync    <= 1'b0;
         mdc_prev    <= 1'b0;
         mdio_meta   <= 1'b0;
         mdio_sync   <= 1'b0;
         pre_cnt     <= '0;
         bit_cnt     <= '0;
         op_hi       <= 1'b0;
         op_rd       <= 1'b0;
         phyad       <= '0;
         regad       <= '0;
         shreg       <= '0;
         rd_got      <= 1'b0;
         rd_word     <= '0;
         mdio_out    <= 1'b0;
         mdio_oe     <= 1'b0;
         reg_addr    <= '0;
         reg_rd_en   <= 1'b0;
         reg_wr_en   <= 1'b0;
         reg_wr_data <= '0;
         frame_error <= 1'b0;
      end else begin
         mdc_meta    <= mdc;
         mdc_sync    <= mdc_meta;
         mdc_prev    <= mdc_sync;
         mdio_meta   <= mdio_in;
         mdio_sync   <= mdio_meta;
         reg_rd_en   <= 1'b0;
         reg_wr_en   <= 1'b0;
         frame_error <= 1'b0;

         if ((state == RD_TA1 || state == RD_TA2) && reg_rd_valid && !rd_got) begin
            rd_got  <= 1'b1;
            rd_word <= reg_rd_data;
         end

         if (mdc_rise) begin
            case (state)
               IDLE: begin
                  if (mdio_sync) begin
                     if (pre_cnt != 6'd63) pre_cnt <= pre_cnt + 6'd1;
                  end else begin
                     if (pre_cnt >= PRE_MIN) state <= ST2;
                     pre_cnt <= '0;
                  end
               end
               ST2: begin
                  if (mdio_sync) begin
                     state   <= OP;
                     bit_cnt <= '0;
                  end else begin
                     frame_error <= 1'b1;
                     state       <= IDLE;
                  end
               end
               OP: begin
                  if (bit_cnt == 5'd0) begin
                     op_hi   <= mdio_sync;
                     bit_cnt <= 5'd1;
                  end else begin
                     bit_cnt <= '0;
                     if (op_hi != mdio_sync) begin
                        op_rd <= op_hi;
                        state <= PHYAD;
                     end else begin
                        frame_error <= 1'b1;
                        state       <= IDLE;
                     end
                  end
               end
               PHYAD: begin
                  phyad <= {phyad[3:0], mdio_sync};
                  if (bit_cnt == 5'd4) begin
                     bit_cnt <= '0;
                     state   <= REGAD;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
               REGAD: begin
                  regad <= {regad[3:0], mdio_sync};
                  if (bit_cnt == 5'd4) begin
                     bit_cnt <= '0;
                     if (phyad == PHY_ADDR) begin
                        reg_addr <= {regad[3:0], mdio_sync};
                        if (op_rd) begin
                           reg_rd_en <= 1'b1;
                           rd_got    <= 1'b0;
                           state     <= RD_TA1;
                        end else begin
                           state <= WR_TA1;
                        end
                     end else begin
                        state <= SKIP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
               SKIP: begin
                  // TA plus 16 data bits of a frame addressed to another PHY.
                  if (bit_cnt == 5'd17) state <= IDLE;
                  else bit_cnt <= bit_cnt + 5'd1;
               end
               RD_TA1: begin
                  mdio_oe  <= 1'b1;
                  mdio_out <= 1'b0;
                  state    <= RD_TA2;
               end
               RD_TA2: begin
                  mdio_out    <= rd_pick[15];
                  shreg       <= {rd_pick[14:0], 1'b0};
                  frame_error <= rd_none;
                  bit_cnt     <= '0;
                  state       <= RD_DATA;
               end
               RD_DATA: begin
                  if (bit_cnt == 5'd15) begin
                     mdio_oe  <= 1'b0;
                     mdio_out <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     mdio_out <= shreg[15];
                     shreg    <= {shreg[14:0], 1'b0};
                     bit_cnt  <= bit_cnt + 5'd1;
                  end
               end
               WR_TA1: begin
                  if (mdio_sync) begin
                     state <= WR_TA2;
                  end else begin
                     frame_error <= 1'b1;
                     state       <= IDLE;
                  end
               end
               WR_TA2: begin
                  if (!mdio_sync) begin
                     bit_cnt <= '0;
                     state   <= WR_DATA;
                  end else begin
                     frame_error <= 1'b1;
                     state       <= IDLE;
                  end
               end
               WR_DATA: begin
                  shreg <= {shreg[14:0], mdio_sync};
                  if (bit_cnt == 5'd15) begin
                     reg_wr_en   <= 1'b1;
                     reg_wr_data <= {shreg[14:0], mdio_sync};
                     state       <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: an MDIO station model drives frames, a register model answers reads, and a
// scoreboard checks register-port strobes and data read back over MDIO.
module tb_mdio_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        mdc;
   logic        mdio_drv;
   logic        mdio_pad;
   logic        mdio_out;
   logic        mdio_oe;
   logic [4:0]  reg_addr;
   logic        reg_rd_en;
   logic        reg_rd_valid;
   logic [15:0] reg_rd_data;
   logic        reg_wr_en;
   logic [15:0] reg_wr_data;
   logic        frame_error;

   always #5 clk = ~clk;

   assign mdio_pad = mdio_oe ? mdio_out : mdio_drv;

   mdio_responder #(.PHY_ADDR(5'd0), .PREAMBLE_MIN(32)) dut (
      .clk(clk), .rst(rst), .mdc(mdc), .mdio_in(mdio_pad),
      .mdio_out(mdio_out), .mdio_oe(mdio_oe), .reg_addr(reg_addr),
      .reg_rd_en(reg_rd_en), .reg_rd_valid(reg_rd_valid), .reg_rd_data(reg_rd_data),
      .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .frame_error(frame_error)
   );

   int n_chk = 0;
   int n_err = 0;
   int n_rd = 0, n_wr = 0, n_ferr = 0;
   logic [4:0]  rd_q[$];
   logic [20:0] wr_q[$];
   logic [15:0] rdata_q[$];
   logic [15:0] mem [32];
   logic        respond;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Register-port model: answers each read request two clocks later.
   initial begin
      int pend;
      logic [15:0] pdata;
      pend = 0;
      pdata = '0;
      reg_rd_valid = 1'b0;
      reg_rd_data = '0;
      forever begin
         @(negedge clk);
         reg_rd_valid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               reg_rd_valid = 1'b1;
               reg_rd_data = pdata;
            end
         end
         if (reg_rd_en && respond) begin
            pend = 2;
            pdata = mem[reg_addr];
         end
      end
   end

   // Strobe monitor and scoreboard pop side.
   initial forever begin
      @(negedge clk);
      if (reg_rd_en) begin
         n_rd++;
         if (rd_q.size() == 0) chk("rd_unexpected", reg_rd_en, 1'b0);
         else chk("rd_addr", reg_addr, rd_q.pop_front());
      end
      if (reg_wr_en) begin
         n_wr++;
         if (wr_q.size() == 0) chk("wr_unexpected", reg_wr_en, 1'b0);
         else chk("wr_addr_data", {reg_addr, reg_wr_data}, wr_q.pop_front());
      end
      if (frame_error) begin
         n_ferr++;
         chk("err_coincide", {reg_rd_en, reg_wr_en}, 2'b00);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic mdc_cycle(input logic d, input logic do_rst, output logic s, output logic o);
      mdio_drv = d;
      repeat (8) @(posedge clk);
      #1;
      s = mdio_pad;
      o = mdio_oe;
      mdc = 1'b1;
      if (do_rst) begin
         repeat (5) @(posedge clk);
         #1;
         chk("oe_before_rst", mdio_oe, 1'b1);
         rst = 1'b1;
         #1;
         chk("oe_in_rst", mdio_oe, 1'b0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         repeat (2) @(posedge clk);
      end else begin
         repeat (8) @(posedge clk);
      end
      #1;
      mdc = 1'b0;
   endtask

   task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] ra, input logic [17:0] tail, input int rst_at,
                        output logic [19:0] samp, output int oe_hi);
      logic s, o;
      logic [13:0] hdr;
      hdr = {2'b01, op, phy, ra};
      oe_hi = 0;
      samp = '0;
      for (int i = 0; i < pre; i++) mdc_cycle(1'b1, 1'b0, s, o);
      for (int i = 13; i >= 0; i--) mdc_cycle(hdr[i], 1'b0, s, o);
      for (int i = 0; i < 20; i++) begin
         mdc_cycle((i < 18) ? tail[17-i] : 1'b1, (i == rst_at), s, o);
         samp[19-i] = s;
         oe_hi += int'(o);
      end
   endtask

   task automatic read_frame(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                             input int rst_at, output logic [15:0] data, output logic ta2,
                             output int oe_hi);
      logic [19:0] samp;
      frame(pre, 2'b10, phy, ra, 18'h3FFFF, rst_at, samp, oe_hi);
      ta2 = samp[18];
      data = samp[17:2];
   endtask

   task automatic write_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] data,
                              output int oe_hi);
      logic [19:0] samp;
      frame(pre, op, phy, ra, {ta, data}, -1, samp, oe_hi);
   endtask

   task automatic zero_bit();
      logic s, o;
      mdc_cycle(1'b0, 1'b0, s, o);
   endtask

   initial begin
      logic [15:0] data;
      logic ta2;
      int oe_hi, rd0, wr0, fe0;

      for (int i = 0; i < 32; i++) mem[i] = 16'(i * 16'h0111 + 16'h1000);
      mem[5] = 16'hA5C3;
      mem[10] = 16'h5A3C;
      respond = 1'b1;
      mdc = 1'b0;
      mdio_drv = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_oe", mdio_oe, 1'b0);
      chk("rst_out", mdio_out, 1'b0);
      chk("rst_rd_en", reg_rd_en, 1'b0);
      chk("rst_wr_en", reg_wr_en, 1'b0);
      chk("rst_addr", reg_addr, 5'd0);
      chk("rst_wr_data", reg_wr_data, 16'd0);
      chk("rst_ferr", frame_error, 1'b0);
      rst = 1'b0;
      repeat (4) @(posedge clk);

      // Read register 5.
      rd0 = n_rd; fe0 = n_ferr;
      rd_q.push_back(5'd5);
      rdata_q.push_back(16'hA5C3);
      read_frame(32, 5'd0, 5'd5, -1, data, ta2, oe_hi);
      chk("rd5_data", data, rdata_q.pop_front());
      chk("rd5_ta2", ta2, 1'b0);
      chk("rd5_oe_span", oe_hi, 17);
      chk("rd5_rd_en_cnt", n_rd - rd0, 1);
      chk("rd5_no_err", n_ferr - fe0, 0);

      // Write register 0x1F.
      wr0 = n_wr;
      wr_q.push_back({5'h1F, 16'h1234});
      write_frame(32, 2'b01, 5'd0, 5'h1F, 2'b10, 16'h1234, oe_hi);
      chk("wr1f_oe", oe_hi, 0);
      chk("wr1f_cnt", n_wr - wr0, 1);

      // Frames for PHY 3 are skipped; a following valid frame still decodes.
      rd0 = n_rd; wr0 = n_wr; fe0 = n_ferr;
      read_frame(32, 5'd3, 5'd5, -1, data, ta2, oe_hi);
      chk("skip_rd_oe", oe_hi, 0);
      write_frame(32, 2'b01, 5'd3, 5'd7, 2'b10, 16'hCAFE, oe_hi);
      chk("skip_wr_oe", oe_hi, 0);
      chk("skip_strobes", (n_rd - rd0) + (n_wr - wr0) + (n_ferr - fe0), 0);
      wr_q.push_back({5'd7, 16'h0F0F});
      write_frame(32, 2'b01, 5'd0, 5'd7, 2'b10, 16'h0F0F, oe_hi);
      chk("after_skip_wr", n_wr - wr0, 1);

      // Preamble boundary: 31 ones ignored, 32 accepted.
      wr0 = n_wr;
      zero_bit();
      write_frame(31, 2'b01, 5'd0, 5'd2, 2'b10, 16'hBEEF, oe_hi);
      chk("pre31_ignored", n_wr - wr0, 0);
      zero_bit();
      wr_q.push_back({5'd2, 16'h4321});
      write_frame(32, 2'b01, 5'd0, 5'd2, 2'b10, 16'h4321, oe_hi);
      chk("pre32_accepted", n_wr - wr0, 1);

      // Illegal opcode.
      rd0 = n_rd; wr0 = n_wr; fe0 = n_ferr;
      write_frame(32, 2'b11, 5'd0, 5'd0, 2'b10, 16'h1234, oe_hi);
      chk("op11_err", n_ferr - fe0, 1);
      chk("op11_no_strobe", (n_rd - rd0) + (n_wr - wr0), 0);

      // Read with no register response.
      respond = 1'b0;
      fe0 = n_ferr;
      rd_q.push_back(5'd9);
      rdata_q.push_back(16'hFFFF);
      read_frame(32, 5'd0, 5'd9, -1, data, ta2, oe_hi);
      chk("norsp_data", data, rdata_q.pop_front());
      chk("norsp_err", n_ferr - fe0, 1);
      chk("norsp_oe_span", oe_hi, 17);
      respond = 1'b1;

      // Reset during data bit 7 of a read, then a full read.
      rd0 = n_rd; fe0 = n_ferr;
      rd_q.push_back(5'd5);
      read_frame(32, 5'd0, 5'd5, 9, data, ta2, oe_hi);
      chk("rst_mid_rd_en", n_rd - rd0, 1);
      rd_q.push_back(5'd10);
      rdata_q.push_back(16'h5A3C);
      read_frame(32, 5'd0, 5'd10, -1, data, ta2, oe_hi);
      chk("post_rst_data", data, rdata_q.pop_front());
      chk("post_rst_ta2", ta2, 1'b0);
      chk("post_rst_err", n_ferr - fe0, 0);

      // Write with bad turnaround.
      wr0 = n_wr; fe0 = n_ferr;
      write_frame(32, 2'b01, 5'd0, 5'd4, 2'b11, 16'h1234, oe_hi);
      chk("ta11_err", n_ferr - fe0, 1);
      chk("ta11_no_wr", n_wr - wr0, 0);
      chk("ta11_oe", oe_hi, 0);

      repeat (10) @(posedge clk);
      chk("rd_q_empty", rd_q.size(), 0);
      chk("wr_q_empty", wr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
